// File: rtl/mfp_eic_irq_scheduler.sv
// mfp_eic_irq_scheduler
// Collects raw interrupt lines into per-line pending state and selects the
// highest-index eligible request for the EIC parameter encoder. It also
// sequences the CPU acknowledge: the acknowledged edge latch is optionally
// cleared, then a hold-off gap passes before the next request is presented.
module mfp_eic_irq_scheduler #(
  parameter int IRQ_COUNT      = 64,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_COUNT-1:0] signal,
  input  logic [IRQ_COUNT-1:0] sense,
  input  logic [IRQ_COUNT-1:0] mask,
  input  logic [IRQ_COUNT-1:0] sw_set,
  input  logic [IRQ_COUNT-1:0] sw_clear,
  input  logic                 autoclear_en,
  input  logic                 irq_ack,
  input  logic [7:0]           ack_number,
  output logic [IRQ_COUNT-1:0] pending,
  output logic [7:0]           irq_number,
  output logic                 irq_detected
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  state_t               state;
  logic [IRQ_COUNT-1:0] edge_latch;
  logic [IRQ_COUNT-1:0] signal_d;
  logic [IRQ_COUNT-1:0] eligible;
  logic [IRQ_COUNT-1:0] set_vec;
  logic [IRQ_COUNT-1:0] clr_vec;
  logic [IRQ_COUNT-1:0] auto_clr;
  logic [7:0]           ack_num_q;
  logic [3:0]           hold_cnt;
  logic [5:0]           top_idx;
  logic                 any_eligible;

  // Level lines bypass the latch, so pending reflects them in the same cycle.
  assign pending  = edge_latch | (signal & ~sense);
  assign eligible = pending & mask;

  // Priority pick: a later (higher) index overrides any earlier hit.
  always_comb begin
    top_idx      = '0;
    any_eligible = 1'b0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (eligible[i]) begin
        top_idx      = 6'(i);
        any_eligible = 1'b1;
      end
    end
  end

  // Auto-clear targets only the acknowledged line and only if it is edge-sensed.
  always_comb begin
    auto_clr = '0;
    if (state == ACK && autoclear_en) begin
      for (int i = 0; i < IRQ_COUNT; i++) begin
        if (ack_num_q == 8'(i)) begin
          auto_clr[i] = sense[i];
        end
      end
    end
  end

  assign set_vec = (signal & ~signal_d & sense) | sw_set;
  assign clr_vec = sw_clear | auto_clr;

  // Edge latches and edge-detect history; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_latch <= '0;
      signal_d   <= '0;
    end else begin
      edge_latch <= set_vec | (edge_latch & ~clr_vec);
      signal_d   <= signal;
    end
  end

  // Request/acknowledge sequencer with registered encoder outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      irq_number   <= '0;
      irq_detected <= 1'b0;
      hold_cnt     <= '0;
      ack_num_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            state        <= REQ;
            irq_number   <= {2'b00, top_idx};
            irq_detected <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state        <= ACK;
            irq_detected <= 1'b0;
            ack_num_q    <= ack_number;
          end else if (any_eligible) begin
            irq_number <= {2'b00, top_idx};
          end else begin
            state        <= IDLE;
            irq_detected <= 1'b0;
          end
        end
        ACK: begin
          state    <= HOLD;
          hold_cnt <= 4'(HOLDOFF_CYCLES);
        end
        HOLD: begin
          irq_detected <= 1'b0;
          if (hold_cnt <= 4'd1) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
